// File: rtl/signed_bcd_display_pkg.sv
// Shared types, segment constants and helpers for the signed BCD display driver.
package signed_bcd_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    // Decimal digits needed to hold 2^width-1.
    function automatic int bcd_digits(input int width);
        return (width * 3) / 10 + 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/signed_bcd_display_if.sv
// Value handshake between the result producer and the display driver.
interface signed_bcd_display_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             ready;

    modport master (output value, valid, input ready);
    modport slave  (input value, valid, output ready);
endinterface

// File: rtl/signed_bcd_display_conv.sv
// Serial double-dabble: one shift-and-adjust iteration per cycle after start.
module bcd_serial_converter
    import signed_bcd_display_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NB    = bcd_digits(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  mag,
    output logic [NB*4-1:0]   bcd,
    output logic              done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [NB*4-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NB; i++)
            if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd   <= '0;
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            bcd   <= '0;
            shreg <= mag;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            bcd   <= {adj[NB*4-2:0], shreg[WIDTH-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/signed_bcd_display.sv
// Signed result to multiplexed active-low 7-segment display with overflow flag.
module signed_bcd_display
    import signed_bcd_display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    signed_bcd_display_if.slave  bus,
    output logic                 overflow,
    output logic [6:0]           segments,
    output logic [DIGITS-1:0]    display_select
);
    localparam int NB = bcd_digits(WIDTH);
    localparam int PN = (NB > DIGITS) ? NB : DIGITS;
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int IW = $clog2(DIGITS);

    state_t                   state, state_nx;
    logic                     start, load, conv_done, sign, ovf_nx;
    logic [WIDTH-1:0]         mag;
    logic [NB*4-1:0]          bcd;
    logic [PN*4-1:0]          bcd_pad;
    logic [DIGITS-1:0][6:0]   disp, disp_nx;
    logic [RW-1:0]            rcnt;
    logic [IW-1:0]            idx;
    int                       n;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the exact magnitude.
    assign mag = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;

    bcd_serial_converter #(.WIDTH(WIDTH)) u_conv (
        .clk(clk), .rst(rst), .start(start), .mag(mag), .bcd(bcd), .done(conv_done)
    );

    always_comb begin
        state_nx  = state;
        bus.ready = 1'b0;
        start     = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.valid) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV:    if (conv_done) state_nx = LOAD;
            LOAD: begin
                load     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_pad            = '0;
        bcd_pad[NB*4-1:0]  = bcd;
        disp_nx            = disp;
        n                  = 1;
        for (int i = 1; i < NB; i++)
            if (bcd[i*4 +: 4] != 4'd0) n = i + 1;
        ovf_nx = (n + int'(sign)) > DIGITS;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_nx)        disp_nx[i] = SEG_E;
            else if (i < n)    disp_nx[i] = seg_decode(bcd_pad[i*4 +: 4]);
            else if (BLANK_LZ) disp_nx[i] = (sign && i == n) ? SEG_MINUS : SEG_BLANK;
            else               disp_nx[i] = (sign && i == DIGITS - 1) ? SEG_MINUS : SEG_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sign     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                disp[i] <= (i == 0 || !BLANK_LZ) ? SEG_ZERO : SEG_BLANK;
        end else begin
            state <= state_nx;
            if (start) sign <= bus.value[WIDTH-1];
            if (load) begin
                disp     <= disp_nx;
                overflow <= ovf_nx;
            end
        end
    end

    // Scan runs freely; loads only change what the current digit shows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt           <= '0;
            idx            <= '0;
            segments       <= SEG_BLANK;
            display_select <= '1;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            segments       <= disp[idx];
            display_select <= ~(DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_signed_bcd_display.sv
// Scoreboard bench: two instances (leading-zero blanking on/off) driven in parallel.
module tb_signed_bcd_display;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic            ovf;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = '0;
    logic        valid = 1'b0;
    logic        ovf_a, ovf_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  sel_a, sel_b;
    int          checks = 0;
    int          errors = 0;
    frame_t      sb_q[$];
    logic [6:0]  tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    signed_bcd_display_if #(.WIDTH(16)) bus_a ();
    signed_bcd_display_if #(.WIDTH(16)) bus_b ();
    assign bus_a.value = value;
    assign bus_a.valid = valid;
    assign bus_b.value = value;
    assign bus_b.valid = valid;

    signed_bcd_display #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus_a), .overflow(ovf_a),
        .segments(seg_a), .display_select(sel_a));

    signed_bcd_display #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .bus(bus_b), .overflow(ovf_b),
        .segments(seg_b), .display_select(sel_b));

    function automatic frame_t model(input int v, input bit blz);
        frame_t f;
        int     d[5];
        int     m, n;
        bit     s;
        s = (v < 0);
        m = s ? -v : v;
        for (int k = 0; k < 5; k++) begin
            d[k] = m % 10;
            m    = m / 10;
        end
        n = 1;
        for (int k = 1; k < 5; k++) if (d[k] != 0) n = k + 1;
        f.ovf = (n + int'(s)) > 4;
        for (int i = 0; i < 4; i++) begin
            if (f.ovf)      f.seg[i] = 7'b0000110;
            else if (i < n) f.seg[i] = tbl[d[i]];
            else if (blz)   f.seg[i] = (s && i == n) ? 7'b0111111 : 7'b1111111;
            else            f.seg[i] = (s && i == 3) ? 7'b0111111 : 7'b1000000;
        end
        return f;
    endfunction

    task automatic push(input int v);
        sb_q.push_back(model(v, 1'b1));
        sb_q.push_back(model(v, 1'b0));
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        @(negedge clk);
        while (!(bus_a.ready && bus_b.ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            errors++;
            $display("FAIL %s ready timeout got 0 exp 1", name);
        end
    endtask

    task automatic send(input int v);
        wait_ready("send");
        value = 16'(v);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        push(v);
    endtask

    task automatic check_frame(input string name);
        frame_t          ea, eb;
        logic [3:0][6:0] ga, gb;
        logic [3:0]      sa, sb;
        wait_ready(name);
        repeat (3) @(negedge clk);
        ea = sb_q.pop_front();
        eb = sb_q.pop_front();
        ga = '1; gb = '1; sa = '0; sb = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (sel_a == ~(4'b0001 << i)) begin ga[i] = seg_a; sa[i] = 1'b1; end
                if (sel_b == ~(4'b0001 << i)) begin gb[i] = seg_b; sb[i] = 1'b1; end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!sa[i] || ga[i] !== ea.seg[i]) begin
                errors++;
                $display("FAIL %s blz digit%0d got %b exp %b", name, i, ga[i], ea.seg[i]);
            end
            checks++;
            if (!sb[i] || gb[i] !== eb.seg[i]) begin
                errors++;
                $display("FAIL %s noblz digit%0d got %b exp %b", name, i, gb[i], eb.seg[i]);
            end
        end
        checks++;
        if (ovf_a !== ea.ovf || ovf_b !== eb.ovf) begin
            errors++;
            $display("FAIL %s overflow got %b/%b exp %b/%b", name, ovf_a, ovf_b, ea.ovf, eb.ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg_a !== 7'h7F || sel_a !== 4'hF) begin
            errors++;
            $display("FAIL reset_outputs got seg %h sel %h exp 7f f", seg_a, sel_a);
        end
        checks++;
        if (bus_a.ready !== 1'b1 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got ready %b ovf %b exp 1 0", bus_a.ready, ovf_a);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_a !== 4'b1110 || seg_a !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first got sel %b seg %b exp 1110 1000000", sel_a, seg_a);
        end
        push(0);
        check_frame("reset_frame");
    endtask

    task automatic test_latency();
        int lows = 0;
        wait_ready("latency");
        value = 16'h04D2;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        push(1234);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus_a.ready) break;
            lows++;
        end
        checks++;
        if (lows != 17) begin
            errors++;
            $display("FAIL latency busy_cycles got %0d exp 17", lows);
        end
        check_frame("latency");
    endtask

    task automatic test_negative();
        send(-42);
        check_frame("negative");
    endtask

    task automatic test_overflow();
        int vals[5] = '{9999, 10000, -999, -1000, -32768};
        foreach (vals[k]) begin
            send(vals[k]);
            check_frame($sformatf("overflow_%0d", vals[k]));
        end
    endtask

    task automatic test_scan();
        int prev = -1, run = 0, bad = 0, cur, zeros;
        bit first = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            zeros = 0;
            cur   = -1;
            for (int i = 0; i < 4; i++) if (!sel_a[i]) begin zeros++; cur = i; end
            if (zeros != 1) bad++;
            if (cur == prev) run++;
            else begin
                if (prev >= 0 && !first) begin
                    checks++;
                    if (run != 4 || cur != (prev + 1) % 4) begin
                        errors++;
                        $display("FAIL scan run got len %0d next %0d exp 4 %0d", run, cur, (prev + 1) % 4);
                    end
                end
                if (prev >= 0) first = 1'b0;
                prev = cur;
                run  = 1;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL scan onehot got %0d bad samples exp 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        wait_ready("busy");
        value = 16'd1111;
        valid = 1'b1;
        @(posedge clk);
        #1 value = 16'd5678;
        push(1111);
        do begin
            @(negedge clk);
            t++;
        end while (!bus_a.ready && t < 100);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_requeue got ready %b exp 1", bus_a.ready);
        end
        check_frame("busy");
    endtask

    task automatic test_reset_mid();
        send(10000);
        check_frame("pre_reset_ovf");
        wait_ready("reset_mid");
        value = 16'h04D2;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got ready %b ovf %b exp 1 0", bus_a.ready, ovf_a);
        end
        @(negedge clk);
        rst = 1'b1;
        push(0);
        check_frame("reset_mid");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_negative();
        test_overflow();
        test_scan();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_bcd_display.md
# signed_bcd_display

Parametrised driver that turns a WIDTH-bit two's-complement result into a multiplexed, active-low 7-segment display of DIGITS digits. It combines sign/magnitude extraction, a serial double-dabble BCD converter, leading-zero blanking, minus-sign placement, overflow indication and digit scanning in one block. It sits between the multiplier result and the board display pins, and accepts results through a valid/ready handshake.

## Interface
- WIDTH, 16: input width, two's complement, legal range 4..32.
- DIGITS, 4: physical display digits, legal range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit stays selected; must be ≥ 1.
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = show them.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- value  in  WIDTH  signed result to display.
- valid  in  1  value is presented.
- ready  out  1  block can accept a value.
- overflow  out  1  displayed value did not fit.
- segments  out  7  {g,f,e,d,c,b,a}, active-low.
- display_select  out  DIGITS  one-hot, active-low; bit 0 is the rightmost digit.

## Operation
- Accept on a rising edge with valid && ready. While ready=0, valid is ignored; nothing is queued.
- On capture:
  - sign = value[WIDTH-1].
  - mag = sign ? -value : value, unsigned WIDTH bits. For -2^(WIDTH-1), mag = 2^(WIDTH-1), which is exact.
- BCD width: NB = (WIDTH*3)/10 + 1 digits, wide enough for 2^WIDTH-1.
- FSM:
  - IDLE: ready=1. On accept → CONV.
  - CONV: WIDTH iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit with the next mag bit from the MSB. After WIDTH iterations → LOAD.
  - LOAD: compute the overflow condition and update the display registers → IDLE.
- Digit count: n = index of the most-significant nonzero BCD nibble + 1; n = 1 for zero.
- Overflow when n + sign > DIGITS. In that case every digit shows 'E' and overflow=1. Otherwise overflow=0.
- Normal display:
  - Digits 0..n-1 show BCD nibbles.
  - BLANK_LZ=1: the minus sign goes in digit n and higher digits are blank.
  - BLANK_LZ=0: unused digits show 0 and the minus sign goes in digit DIGITS-1.
- Segment codes: 0=7'b1000000, minus=7'b0111111, blank=7'b1111111, E=7'b0000110, plus the standard active-low codes for digits 1–9.
- Scan:
  - A refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances, wrapping from DIGITS-1 to 0.
  - segments and display_select are registered and updated every cycle from the current index and the display registers.

## Timing
- Reset values:
  - Outputs: ready=1, overflow=0, segments=7'b1111111, display_select all ones.
  - Internal: state IDLE, refresh counter 0, digit index 0, display registers hold value 0 (digit 0 = '0', the rest blank or 0 per BLANK_LZ).
- First cycle after reset release: the scan starts, digit 0 is selected and shows '0'.
- Handshake sequence, for an accept at edge T:
  - Edge T: ready goes 0.
  - Edges T+1..T+WIDTH: conversion.
  - Edge T+WIDTH+1: display registers and overflow update, ready goes 1.
  - Edge T+WIDTH+2: earliest next accept.
- Output latency: new content reaches segments one edge after the load, at T+WIDTH+2, on whichever digit is currently selected.
- Scan timing and the digit index are unaffected by loads; no glitch on display_select.
- Reset asserted mid-conversion: immediate return to the reset state and the partial result is discarded.
- Zero input: shows single '0' when BLANK_LZ=1; sign is always 0.

## Structure
- Package signed_bcd_display_pkg holds:
  - segment constants (SEG_BLANK, SEG_MINUS, SEG_E);
  - the state enum {IDLE, CONV, LOAD};
  - function seg_decode(nibble) returning the active-low code.
- Sub-module bcd_serial_converter, parametrised by WIDTH:
  - Behaviour: start/mag in; bcd (NB×4) and done out; one iteration per cycle.
  - Ownership: the top owns the FSM, overflow logic and scan.

## Test plan
Use REFRESH_DIV=4, WIDTH=16, DIGITS=4, BLANK_LZ=1 unless noted.
- Reset: rst=0 → segments=7'h7F, display_select=4'hF, ready=1. After release, display_select=4'b1110 with segments=7'b1000000 ('0'), and the other digits are blank.
- Latency: value=16'h04D2 (1234) accepted at T → ready=0 for 17 cycles, ready=1 at T+17. Scan shows 4,3,2,1 on digits 0..3 (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001); overflow=0.
- Negative: value=16'hFFD6 (-42) → digits 0..3 = '2','4','-',blank. With BLANK_LZ=0 → '2','4','0','-'.
- Overflow bounds:
  - 9999 → fits.
  - 10000 → overflow=1, all digits 7'b0000110.
  - -999 → fits, shown as '-999'.
  - -1000 → overflow.
  - 16'h8000 → overflow.
- Scan: each display_select bit is low for exactly 4 consecutive cycles, in order 0,1,2,3,0; never more than one bit low.
- Handshake and reset:
  - valid held high while busy → second value ignored, first value displayed.
  - rst pulsed at T+5 during conversion → ready=1, display returns to '0', overflow=0.
